// File: rtl/mem_access_stage.sv
// Memory-access stage of the multicycle datapath: launches one handshaked read or
// write per start and hands latched (mdrOut) and raw (memOut) read data to writeback.
module mem_access_stage #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] mdrOut,
  output logic [WIDTH-1:0] memOut,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t        state;
  logic [CW-1:0] count;

  // Request fields are only loaded in IDLE, so they stay stable for the whole REQ phase.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mdrOut    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_we    <= we;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            count     <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          // An acknowledge in the final timeout cycle still completes the access.
          if (mem_ack) begin
            if (!mem_we) mdrOut <= mem_rdata;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            count <= count + CW'(1);
            if (TIMEOUT != 0 && count == LAST) begin
              mem_req <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
              state   <= ERR;
            end
          end
        end
        DONE, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Raw one-cycle-delayed view of the memory bus, independent of the handshake.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) memOut <= '0;
    else        memOut <= mem_rdata;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: each access pushes its expected outcome to a
// scoreboard that is popped when done or err appears.
module tb_mem_access_stage;

  logic        CLK;
  logic        reset;
  logic        start;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] mdrOut;
  logic [15:0] memOut;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic        isErr;
    logic [15:0] mdr;
    int          latency;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] modelMdr;
  int          testCount;
  int          failCount;

  mem_access_stage #(.WIDTH(16), .TIMEOUT(15)) dut (
    .CLK(CLK), .reset(reset), .start(start), .we(we), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mdrOut(mdrOut), .memOut(memOut),
    .busy(busy), .done(done), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Launches one access; the memory acks in REQ cycle ackAt (0 = never).
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d,
                               input int ackAt, input logic [15:0] rd, input logic stray);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   finished;
    e.isErr   = (ackAt == 0 || ackAt > 15);
    e.latency = e.isErr ? 15 : ackAt;
    e.mdr     = (w || e.isErr) ? modelMdr : rd;
    modelMdr  = e.mdr;
    sb.push_back(e);

    @(negedge CLK);
    start = 1'b1; we = w; addr = a; wdata = d;
    cyc = 0;
    finished = 0;
    while (!finished && cyc < 40) begin
      @(negedge CLK);
      checkOutput("memOut_delay", {16'h0, memOut}, {16'h0, mem_rdata});
      if (done || err) begin
        finished = 1;
        mem_ack = 1'b0;
        start = stray;
        if (sb.size() == 0) begin
          checkOutput("sb_empty", 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          checkOutput("done_flag", {31'h0, done}, {31'h0, !got.isErr});
          checkOutput("err_flag", {31'h0, err}, {31'h0, got.isErr});
          checkOutput("latency", cyc, got.latency);
          checkOutput("mdrOut", {16'h0, mdrOut}, {16'h0, got.mdr});
          checkOutput("req_dropped", {30'h0, mem_req, busy}, 32'h0);
        end
      end else begin
        cyc++;
        start = stray && (cyc == 2);
        checkOutput("req_busy", {30'h0, mem_req, busy}, 32'h3);
        checkOutput("mem_addr", {16'h0, mem_addr}, {16'h0, a});
        checkOutput("mem_we", {31'h0, mem_we}, {31'h0, w});
        checkOutput("mem_wdata", {16'h0, mem_wdata}, {16'h0, d});
        mem_ack   = (cyc == ackAt);
        mem_rdata = (cyc == ackAt) ? rd : 16'($urandom);
      end
    end
    if (!finished) checkOutput("watchdog", 32'd0, 32'd1);

    @(negedge CLK);
    start = 1'b0;
    checkOutput("pulse_low", {30'h0, done, err}, 32'h0);
    checkOutput("idle_req", {31'h0, mem_req}, 32'h0);
    @(negedge CLK);
    checkOutput("no_requeue", {30'h0, mem_req, busy}, 32'h0);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    modelMdr  = 16'h0;
    reset = 1'b0; start = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = 16'hFFFF;

    repeat (2) @(negedge CLK);
    checkOutput("rst_ctrl", {27'h0, mem_req, mem_we, busy, done, err}, 32'h0);
    checkOutput("rst_addr", {mem_addr, mem_wdata}, 32'h0);
    checkOutput("rst_data", {mdrOut, memOut}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("idle_after_rst", {30'h0, mem_req, busy}, 32'h0);
    checkOutput("memOut_idle", {16'h0, memOut}, 32'h0000FFFF);

    $display("[TB] read with ack on third cycle, stray starts");
    applyStimulus(1'b0, 16'h0040, 16'h0000, 3, 16'hABCD, 1'b1);
    $display("[TB] write then read-back");
    applyStimulus(1'b1, 16'h0041, 16'h1234, 1, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0041, 16'h0000, 1, 16'h1234, 1'b0);
    $display("[TB] timeout and last-cycle ack");
    applyStimulus(1'b0, 16'h0050, 16'h0000, 0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0051, 16'h0000, 15, 16'h0BEE, 1'b0);

    $display("[TB] stray ack in idle");
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    @(negedge CLK);
    checkOutput("stray_ack_mdr", {16'h0, mdrOut}, {16'h0, modelMdr});
    checkOutput("stray_ack_memOut", {16'h0, memOut}, 32'h00005555);
    checkOutput("stray_ack_ctrl", {29'h0, mem_req, busy, done}, 32'h0);
    mem_ack = 1'b0;
    @(negedge CLK);
    checkOutput("stray_ack_err", {31'h0, err}, 32'h0);

    $display("[TB] reset mid-access");
    start = 1'b1; we = 1'b0; addr = 16'h0060;
    @(negedge CLK);
    start = 1'b0;
    checkOutput("mid_req_up", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b0;
    #1 checkOutput("mid_req_async", {30'h0, mem_req, busy}, 32'h0);
    checkOutput("mid_mdr_cleared", {16'h0, mdrOut}, 32'h0);
    modelMdr = 16'h0;
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    checkOutput("post_rst_idle", {31'h0, mem_req}, 32'h0);
    applyStimulus(1'b0, 16'h0060, 16'h0000, 2, 16'h7777, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
